// File: rtl/press_event_decoder.sv
// press_event_decoder
//
// Purpose:
//   Classifies debounced push-button pulses into single click, double click,
//   long press and (optionally) auto-repeat events. All timing is counted in
//   ticks of a one-cycle time-base strobe, so the counter stays narrow.
//
// Configuration macro:
//   PED_AUTOREPEAT_EN - when defined, the HELD state emits an auto_repeat
//                       pulse every RPT_TICKS ticks until release. When
//                       undefined, auto_repeat is tied to 0 and the repeat
//                       timing is not built.
//
// Ports:
//   clk          in  1  system clock, rising edge
//   reset        in  1  asynchronous active-low reset (0 = reset)
//   tick         in  1  time-base strobe, 1 clk wide
//   pb_down      in  1  1-clk pulse: button just pressed
//   pb_up        in  1  1-clk pulse: button just released
//   click        out 1  1-clk pulse: single click recognised
//   dbl_click    out 1  1-clk pulse: double click recognised
//   long_press   out 1  1-clk pulse: hold threshold reached
//   auto_repeat  out 1  1-clk pulse: auto-repeat while held
//                       (named auto_repeat because "repeat" is a reserved word)
//   busy         out 1  level: registered (next state != IDLE)
module press_event_decoder #(
  parameter int CNT_W      = 16,
  parameter int LONG_TICKS = 500,
  parameter int DBL_TICKS  = 150,
  parameter int RPT_TICKS  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pb_down,
  input  logic pb_up,
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic auto_repeat,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  // An N-tick timeout fires when tick=1 while cnt==N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Simultaneous press and release pulses are treated as no input at all.
  logic down;
  logic up;
  assign down = pb_down & ~pb_up;
  assign up   = pb_up & ~pb_down;

  logic tick_inc;
  assign tick_inc = tick && (cnt != {CNT_W{1'b1}});  // saturate, never wrap

`ifdef PED_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_TICKS - 1);
  logic rpt_hit;
  assign rpt_hit = tick && (cnt == RPT_LAST);
`else
  assign auto_repeat = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
      busy       <= 1'b0;
`ifdef PED_AUTOREPEAT_EN
      auto_repeat <= 1'b0;
`endif
    end else begin
      // Event outputs are single-cycle pulses; busy follows the state that
      // will be current after this edge.
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
      busy       <= (state != IDLE);
`ifdef PED_AUTOREPEAT_EN
      auto_repeat <= 1'b0;
`endif
      if (tick_inc) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;  // nothing is timed while idle
          if (down) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          // Release wins over a same-cycle long-press timeout.
          if (up) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (tick && cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
            cnt        <= '0;
          end
        end
        WAIT2: begin
          // A second press wins over a same-cycle double-click timeout.
          if (down) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (tick && cnt == DBL_LAST) begin
            click <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        PRESS2: begin
          if (up) begin
            dbl_click <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
          end
        end
        HELD: begin
          // Release wins over a same-cycle repeat timeout.
          if (up) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
`ifdef PED_AUTOREPEAT_EN
          else if (rpt_hit) begin
            auto_repeat <= 1'b1;
            cnt         <= '0;
          end
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_event_decoder.sv
// tb_press_event_decoder
//
// Purpose:
//   Directed scoreboard bench for press_event_decoder (LONG_TICKS=8,
//   DBL_TICKS=4, RPT_TICKS=3). Stimulus pushes the expected event and the
//   cycle it must appear in; a monitor on the falling edge pops and compares
//   whenever any event output is high.
//
// Ports: none (top-level bench).
module tb_press_event_decoder;

  localparam logic [3:0] EV_CLICK = 4'b1000;
  localparam logic [3:0] EV_DBL   = 4'b0100;
  localparam logic [3:0] EV_LONG  = 4'b0010;
  localparam logic [3:0] EV_RPT   = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick;
  logic pb_down = 1'b0;
  logic pb_up = 1'b0;
  logic click, dbl_click, long_press, auto_repeat, busy;

  int cyc = 0;
  bit tick_all = 1'b1;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] ev;
    int         at;
  } exp_t;
  exp_t q[$];

  press_event_decoder #(
    .CNT_W(16), .LONG_TICKS(8), .DBL_TICKS(4), .RPT_TICKS(3)
  ) dut (
    .clk(clk), .reset(rst_n), .tick(tick), .pb_down(pb_down), .pb_up(pb_up),
    .click(click), .dbl_click(dbl_click), .long_press(long_press),
    .auto_repeat(auto_repeat), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tick = tick_all | (cyc % 4 == 0);

  // Monitor: every observed event must match the head of the queue.
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t e;
    ev = {click, dbl_click, long_press, auto_repeat};
    if (ev != 4'b0000) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got ev=%b at cycle %0d, expected none", ev, cyc);
      end else begin
        e = q.pop_front();
        if (e.ev != ev || e.at != cyc) begin
          bad++;
          $display("FAIL event: got ev=%b at cycle %0d, expected ev=%b at cycle %0d",
                   ev, cyc, e.ev, e.at);
        end else
          $display("event ev=%b at cycle %0d ok", ev, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic pulse(input logic d, input logic u);
    pb_down = d;
    pb_up   = u;
    step(1);
    pb_down = 1'b0;
    pb_up   = 1'b0;
  endtask

  task automatic expect_ev(input logic [3:0] ev, input int at);
    exp_t e;
    e.ev = ev;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else
      $display("check %s = %0d ok", name, got);
  endtask

  task automatic drain(input string name);
    check(name, q.size(), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;

    // 1: reset held with random pulses -> everything quiet
    for (int i = 0; i < 5; i++) begin
      pb_down = 1'($urandom_range(0, 1));
      pb_up   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_outputs", int'({click, dbl_click, long_press, auto_repeat, busy}), 0);
    end
    pb_down = 1'b0;
    pb_up   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    check("after_reset_busy", int'(busy), 0);

    // Simultaneous down/up in IDLE is ignored.
    pulse(1'b1, 1'b1);
    check("both_pulses_busy", int'(busy), 0);

    // 2: single click, 5 clk after pb_up
    step(1);
    c0 = cyc;
    pulse(1'b1, 1'b0);
    check("s2_busy_press", int'(busy), 1);
    goto_cyc(c0 + 3);
    expect_ev(EV_CLICK, c0 + 8);
    pulse(1'b0, 1'b1);
    goto_cyc(c0 + 14);
    drain("s2_drain");

    // 3: double click
    c0 = cyc;
    expect_ev(EV_DBL, c0 + 10);
    pulse(1'b1, 1'b0);
    goto_cyc(c0 + 2); pulse(1'b0, 1'b1);
    goto_cyc(c0 + 4); pulse(1'b1, 1'b0);
    goto_cyc(c0 + 9); pulse(1'b0, 1'b1);
    goto_cyc(c0 + 16);
    drain("s3_drain");

    // 4: long press, optional repeats, silent release (stray pb_down in HELD)
    c0 = cyc;
    expect_ev(EV_LONG, c0 + 9);
`ifdef PED_AUTOREPEAT_EN
    expect_ev(EV_RPT, c0 + 12);
    expect_ev(EV_RPT, c0 + 15);
    expect_ev(EV_RPT, c0 + 18);
`endif
    pulse(1'b1, 1'b0);
    goto_cyc(c0 + 10); pulse(1'b1, 1'b0);
    goto_cyc(c0 + 11);
    check("s4_busy_held", int'(busy), 1);
    goto_cyc(c0 + 20); pulse(1'b0, 1'b1);
    goto_cyc(c0 + 28);
    drain("s4_drain");

    // 5: reset 2 clk into WAIT2 drops the pending click
    c0 = cyc;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    goto_cyc(c0 + 4);
    rst_n = 1'b0;
    step(2);
    check("s5_busy_in_reset", int'(busy), 0);
    rst_n = 1'b1;
    goto_cyc(c0 + 14);
    drain("s5_drain");
    c0 = cyc;
    pulse(1'b1, 1'b0);
    goto_cyc(c0 + 3);
    expect_ev(EV_CLICK, c0 + 8);
    pulse(1'b0, 1'b1);
    goto_cyc(c0 + 14);
    drain("s5_click_drain");

    // 6: second press on the 4th WAIT2 tick beats the click timeout
    c0 = cyc;
    expect_ev(EV_DBL, c0 + 8);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    goto_cyc(c0 + 5); pulse(1'b1, 1'b0);
    goto_cyc(c0 + 7); pulse(1'b0, 1'b1);
    goto_cyc(c0 + 14);
    drain("s6_drain");

    // 6b: click with a tick every 4th clk
    tick_all = 1'b0;
    while (cyc % 4 != 0) step(1);
    c0 = cyc;
    pulse(1'b1, 1'b0);
    goto_cyc(c0 + 3);
    expect_ev(EV_CLICK, c0 + 17);
    pulse(1'b0, 1'b1);
    goto_cyc(c0 + 24);
    drain("s6b_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
